cnn_top: RTL and testbench
==========================

# cnn_top

Tiny fixed-topology integer CNN inference engine used as the chip-level compute top. Weights (54 bytes) and one 8×8 single-channel image (64 bytes) are streamed in byte-serially on a shared input bus. On request it computes conv3×3 (1→3 ch) → ReLU → maxpool 2×2 → conv3×3 (3→1 ch) and presents a single signed 8-bit result with a completion flag.

## Interface
- SHIFT1, 7, arithmetic right shift applied to conv1 accumulators before saturation
- SHIFT2, 7, arithmetic right shift applied to conv2 accumulator before saturation
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-high (asserted when rst_n=1)
- mode  input  1  load target while ram_en=1: 1 = weight memory, 0 = image memory
- din  input  8  load byte, signed int8 (two's complement)
- ram_en  input  1  load strobe; one byte written per clock while high
- calc_en  input  1  level request to compute; must stay high until result consumed
- dout  output  8  signed int8 result
- out_data_flag  output  1  result-valid flag

## Operation
- Storage: weight RAM 54×8, image RAM 64×8. Contents not cleared by reset; weights persist across images.
- Loading: each cycle with ram_en=1, din written to selected RAM at its write pointer, pointer +1. Weight pointer wraps 53→0, image pointer 63→0. Both pointers clear to 0 whenever ram_en=0.
- Image layout: address = y*8 + x (row-major, y,x ∈ 0..7).
- Weight layout: conv1 address = oc*9 + ky*3 + kx (oc 0..2); conv2 address = 27 + ic*9 + ky*3 + kx (ic 0..2). No biases.
- conv1: valid 3×3, 8×8 → 6×6×3; acc1 = Σ img[y+ky][x+kx]·w1[oc][ky][kx] (signed, ≥20-bit accumulator); a = sat8(acc1 >>> SHIFT1); ReLU max(a,0).
- maxpool 2×2 stride 2 → 3×3×3 (values 0..127).
- conv2: single 3×3×3 window → acc2 = Σ p[ic][ky][kx]·w2[ic][ky][kx]; dout = sat8(acc2 >>> SHIFT2). No ReLU on output.
- >>> is arithmetic (floor toward −∞); sat8 clamps to [−128,127].
- FSM: IDLE → (calc_en=1 & ram_en=0) → CONV1 → CONV2 → DONE. DONE holds dout, flag=1 until calc_en=0, then IDLE.
- calc_en=1 while ram_en=1: loading has priority; FSM stays IDLE.
- calc_en dropped mid-computation: abort to IDLE next cycle, flag stays 0, dout unchanged.
- Datapath: one signed 8×8 MAC per cycle, sequenced (oc, pooled pos, 2×2 sub-pos, tap); running max per pool window.

## Timing
- Reset: dout=0, out_data_flag=0, FSM IDLE, pointers 0.
- Write of byte presented before edge k lands at edge k; image usable on the next cycle after ram_en falls.
- Latency: out_data_flag rises ≤1200 cycles after the first rising edge sampling calc_en=1 (972 conv1 MACs + 27 conv2 MACs + overhead); fixed for given topology.
- dout valid the same cycle out_data_flag rises; stable until next completed computation.
- out_data_flag clears on the first edge at which calc_en=0 is sampled.
- Reset mid-operation: immediate return to reset state; RAM contents retained.

## Test plan
- Reset: rst_n=1 for 1 cycle → dout=0, out_data_flag=0; hold calc_en=0 → flag never rises.
- All 54 weights 0, any image, calc_en=1 → flag within 1200 cycles, dout=0; drop calc_en → flag 0 next edge.
- Image all 127, w1 all 127, w2 all 1 → conv1 saturates 127, acc2=3429 → dout=26 (0x1A).
- Same but w2 all −1 → acc2=−3429 → dout=−27 (0xE5).
- w1 all −127, image all 127, w2 any → conv1 −128, ReLU 0 → dout=0.
- Abort/reuse: drop calc_en after 100 cycles → no flag; reload new image (weights untouched), calc_en=1 → correct result; repeat 100 random images against a golden model with back-to-back load/compute.

Source files
------------

// File: rtl/cnn_if.sv
`default_nettype none
// ============================================================================
// Module  : cnn_if
// Brief   : Load/compute bus between the host and the CNN engine.
// Revision: 1.0
// ============================================================================
interface cnn_if;
    logic              mode;
    logic signed [7:0] din;
    logic              ram_en;
    logic              calc_en;
    logic signed [7:0] dout;
    logic              out_data_flag;

    modport master (
        output mode, din, ram_en, calc_en,
        input  dout, out_data_flag
    );

    modport slave (
        input  mode, din, ram_en, calc_en,
        output dout, out_data_flag
    );
endinterface
`default_nettype wire

// File: rtl/cnn_top.sv
`default_nettype none
// ============================================================================
// Module  : cnn_top
// Brief   : conv3x3(1->3) -> ReLU -> maxpool2x2 -> conv3x3(3->1), one MAC/cycle.
// Revision: 1.0
// ============================================================================
module cnn_top #(
    parameter int SHIFT1 = 7,
    parameter int SHIFT2 = 7
) (
    input  wire logic clk,
    input  wire logic rst_n,
    cnn_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV1 = 2'd1,
        S_CONV2 = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic signed [7:0] sat8(input logic signed [23:0] v);
        if (v > 24'sd127)
            return 8'sh7f;
        else if (v < -24'sd128)
            return 8'sh80;
        else
            return v[7:0];
    endfunction

    state_t             r_state;
    logic signed [7:0]  r_wram [54];
    logic signed [7:0]  r_iram [64];
    logic [6:0]         r_pool [27];
    logic [5:0]         r_wptr;
    logic [5:0]         r_iptr;

    logic [1:0]         r_kx, r_ky, r_px, r_py, r_oc;
    logic               r_sx, r_sy;
    logic [4:0]         r_c2;
    logic signed [23:0] r_acc;
    logic [6:0]         r_max;
    logic signed [7:0]  r_dout;
    logic               r_flag;

    logic [2:0]         w_iy, w_ix;
    logic [5:0]         w_img_addr, w_w1_addr, w_w2_addr;
    logic [4:0]         w_pool_waddr;
    logic signed [7:0]  w_a, w_b;
    logic signed [15:0] w_prod;
    logic signed [23:0] w_acc_next;
    logic signed [7:0]  w_c1_sat;
    logic [6:0]         w_relu, w_max_next;
    logic               w_last_tap, w_last_sub, w_go, w_pool_we;

    // ---------------- Load path ----------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wptr <= 6'd0;
            r_iptr <= 6'd0;
        end else if (!bus.ram_en) begin
            r_wptr <= 6'd0;
            r_iptr <= 6'd0;
        end else if (bus.mode) begin
            r_wptr <= (r_wptr == 6'd53) ? 6'd0 : r_wptr + 6'd1;
        end else begin
            r_iptr <= r_iptr + 6'd1;
        end
    end

    // Storage is deliberately outside the reset domain so weights survive reset.
    always_ff @(posedge clk) begin
        if (bus.ram_en && !rst_n) begin
            if (bus.mode)
                r_wram[r_wptr] <= bus.din;
            else
                r_iram[r_iptr] <= bus.din;
        end
    end

    // ---------------- Datapath ----------------
    assign w_iy       = {r_py, 1'b0} + {2'b00, r_sy} + {1'b0, r_ky};
    assign w_ix       = {r_px, 1'b0} + {2'b00, r_sx} + {1'b0, r_kx};
    assign w_img_addr = {w_iy, w_ix};
    assign w_w1_addr  = {4'd0, r_oc} * 6'd9 + {4'd0, r_ky} * 6'd3 + {4'd0, r_kx};
    assign w_w2_addr  = 6'd27 + {1'b0, r_c2};
    assign w_pool_waddr = {3'd0, r_oc} * 5'd9 + {3'd0, r_py} * 5'd3 + {3'd0, r_px};

    always_comb begin
        w_a = r_iram[w_img_addr];
        w_b = r_wram[w_w1_addr];
        if (r_state == S_CONV2) begin
            w_a = {1'b0, r_pool[r_c2]};
            w_b = r_wram[w_w2_addr];
        end
    end

    assign w_prod     = w_a * w_b;
    assign w_acc_next = r_acc + {{8{w_prod[15]}}, w_prod};
    assign w_c1_sat   = sat8(w_acc_next >>> SHIFT1);
    assign w_relu     = w_c1_sat[7] ? 7'd0 : w_c1_sat[6:0];
    assign w_last_tap = (r_kx == 2'd2) && (r_ky == 2'd2);
    assign w_last_sub = r_sx && r_sy;
    // Running max restarts on the first sub-position of every pool window.
    assign w_max_next = ((!r_sx && !r_sy) || (w_relu > r_max)) ? w_relu : r_max;
    assign w_go       = bus.calc_en && !bus.ram_en;
    assign w_pool_we  = !rst_n && (r_state == S_CONV1) && w_go && w_last_tap && w_last_sub;

    always_ff @(posedge clk) begin
        if (w_pool_we)
            r_pool[w_pool_waddr] <= w_max_next;
    end

    // ---------------- Sequencer ----------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_kx <= 2'd0; r_ky <= 2'd0; r_px <= 2'd0; r_py <= 2'd0; r_oc <= 2'd0;
            r_sx <= 1'b0; r_sy <= 1'b0;
            r_c2 <= 5'd0;
            r_acc <= 24'sd0;
            r_max <= 7'd0;
            r_dout <= 8'sd0;
            r_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_flag <= 1'b0;
                    if (w_go) begin
                        r_state <= S_CONV1;
                        r_kx <= 2'd0; r_ky <= 2'd0; r_px <= 2'd0; r_py <= 2'd0; r_oc <= 2'd0;
                        r_sx <= 1'b0; r_sy <= 1'b0;
                        r_c2 <= 5'd0;
                        r_acc <= 24'sd0;
                    end
                end
                S_CONV1: begin
                    if (!w_go) begin
                        r_state <= S_IDLE;
                    end else if (!w_last_tap) begin
                        r_acc <= w_acc_next;
                        if (r_kx == 2'd2) begin
                            r_kx <= 2'd0;
                            r_ky <= r_ky + 2'd1;
                        end else begin
                            r_kx <= r_kx + 2'd1;
                        end
                    end else begin
                        r_acc <= 24'sd0;
                        r_max <= w_max_next;
                        r_kx  <= 2'd0;
                        r_ky  <= 2'd0;
                        if (!r_sx) begin
                            r_sx <= 1'b1;
                        end else begin
                            r_sx <= 1'b0;
                            if (!r_sy) begin
                                r_sy <= 1'b1;
                            end else begin
                                r_sy <= 1'b0;
                                if (r_px != 2'd2) begin
                                    r_px <= r_px + 2'd1;
                                end else begin
                                    r_px <= 2'd0;
                                    if (r_py != 2'd2) begin
                                        r_py <= r_py + 2'd1;
                                    end else begin
                                        r_py <= 2'd0;
                                        if (r_oc != 2'd2) begin
                                            r_oc <= r_oc + 2'd1;
                                        end else begin
                                            r_oc    <= 2'd0;
                                            r_c2    <= 5'd0;
                                            r_state <= S_CONV2;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                S_CONV2: begin
                    if (!w_go) begin
                        r_state <= S_IDLE;
                    end else if (r_c2 == 5'd26) begin
                        r_dout  <= sat8(w_acc_next >>> SHIFT2);
                        r_flag  <= 1'b1;
                        r_acc   <= 24'sd0;
                        r_state <= S_DONE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_c2  <= r_c2 + 5'd1;
                    end
                end
                S_DONE: begin
                    if (!bus.calc_en) begin
                        r_flag  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dout          = r_dout;
    assign bus.out_data_flag = r_flag;

endmodule
`default_nettype wire

// File: tb/tb_cnn_top.sv
`default_nettype none
// ============================================================================
// Module  : tb_cnn_top
// Brief   : Self-checking bench for cnn_top against a direct CNN model.
// Revision: 1.0
// ============================================================================
module tb_cnn_top;

    localparam int SH1 = 7;
    localparam int SH2 = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cnn_if bus();

    cnn_top #(.SHIFT1(SH1), .SHIFT2(SH2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_img [64];
    int m_w   [54];

    typedef struct {
        int img;
        int w1;
        int w2;
        int exp;
    } vec_t;
    vec_t vecs [7];

    function automatic int sat8(int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int model();
        int pool [27];
        int acc, a, mx, acc2;
        for (int oc = 0; oc < 3; oc++)
            for (int py = 0; py < 3; py++)
                for (int px = 0; px < 3; px++) begin
                    mx = 0;
                    for (int sy = 0; sy < 2; sy++)
                        for (int sx = 0; sx < 2; sx++) begin
                            acc = 0;
                            for (int ky = 0; ky < 3; ky++)
                                for (int kx = 0; kx < 3; kx++)
                                    acc += m_img[(2*py+sy+ky)*8 + 2*px+sx+kx] * m_w[oc*9 + ky*3 + kx];
                            a = sat8(acc >>> SH1);
                            if (a < 0) a = 0;
                            if (a > mx) mx = a;
                        end
                    pool[oc*9 + py*3 + px] = mx;
                end
        acc2 = 0;
        for (int i = 0; i < 27; i++)
            acc2 += pool[i] * m_w[27 + i];
        return sat8(acc2 >>> SH2);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_w();
        for (int i = 0; i < 54; i++) begin
            @(negedge clk);
            bus.mode   = 1'b1;
            bus.ram_en = 1'b1;
            bus.din    = m_w[i][7:0];
        end
        @(negedge clk);
        bus.ram_en = 1'b0;
    endtask

    task automatic load_img();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.mode   = 1'b0;
            bus.ram_en = 1'b1;
            bus.din    = m_img[i][7:0];
        end
        @(negedge clk);
        bus.ram_en = 1'b0;
    endtask

    task automatic compute(output int res, output int cyc, output bit got);
        @(negedge clk);
        bus.calc_en = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 1300) begin
            @(negedge clk);
            cyc++;
            if (bus.out_data_flag) got = 1'b1;
        end
        res = int'(bus.dout);
    endtask

    task automatic run_case(input string nm, input int exp);
        int res, cyc;
        bit got;
        compute(res, cyc, got);
        check({nm, "_flag"}, int'(got), 1);
        check({nm, "_latency"}, int'(cyc <= 1200), 1);
        check(nm, res, exp);
        @(negedge clk);
        bus.calc_en = 1'b0;
        @(negedge clk);
        check({nm, "_flagclr"}, int'(bus.out_data_flag), 0);
    endtask

    task automatic rand_img();
        for (int i = 0; i < 64; i++) m_img[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic rand_w();
        for (int i = 0; i < 54; i++) m_w[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        bit seen;
        int prev;

        vecs[0] = '{127,  127,    1,   26};
        vecs[1] = '{127,  127,   -1,  -27};
        vecs[2] = '{127, -127,    5,    0};
        vecs[3] = '{ 55,    0,    0,    0};
        vecs[4] = '{-128,-128, -128, -128};
        vecs[5] = '{100,   50,    2,   53};
        vecs[6] = '{ 10,   20,    3,    8};

        bus.mode = 1'b0; bus.din = 8'sd0; bus.ram_en = 1'b0; bus.calc_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_dout", int'(bus.dout), 0);
        check("reset_flag", int'(bus.out_data_flag), 0);
        rst_n = 1'b0;

        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_data_flag) seen = 1'b1;
        end
        check("idle_no_flag", int'(seen), 0);

        foreach (vecs[v]) begin
            for (int i = 0; i < 64; i++) m_img[i] = vecs[v].img;
            for (int i = 0; i < 27; i++) m_w[i] = vecs[v].w1;
            for (int i = 27; i < 54; i++) m_w[i] = vecs[v].w2;
            load_w();
            load_img();
            run_case($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Abort after 100 cycles: no flag, dout holds the previous result.
        rand_w();
        rand_img();
        load_w();
        load_img();
        prev = int'(bus.dout);
        @(negedge clk);
        bus.calc_en = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.out_data_flag) seen = 1'b1;
        end
        bus.calc_en = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_flag", int'(seen | bus.out_data_flag), 0);
        check("abort_dout_hold", int'(bus.dout), prev);
        rand_img();
        load_img();
        run_case("after_abort", model());

        // Reset mid-computation: outputs clear, RAM contents survive.
        @(negedge clk);
        bus.calc_en = 1'b1;
        repeat (500) @(negedge clk);
        rst_n = 1'b1;
        bus.calc_en = 1'b0;
        @(negedge clk);
        check("midrst_dout", int'(bus.dout), 0);
        check("midrst_flag", int'(bus.out_data_flag), 0);
        rst_n = 1'b0;
        run_case("after_reset", model());

        for (int r = 0; r < 40; r++) begin
            if (r % 8 == 0) begin
                rand_w();
                load_w();
            end
            rand_img();
            load_img();
            run_case($sformatf("rand%0d", r), model());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
